// File: rtl/ym_frame_sequencer_if.sv
// ym_frame_sequencer_if: Wishbone write-master bus between the
// frame sequencer and the wb_ym2149 slave.
interface ym_frame_sequencer_if;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_ack_i
  );
endinterface

// File: rtl/ym_frame_sequencer.sv
// ym_frame_sequencer: plays FIFO'd register-write frames on each frame tick.
// Optional YM_SEQ_SKIP_REDUNDANT_EN: skip writes equal to a per-address shadow.
module ym_frame_sequencer #(
  parameter int CLK_FREQ_HZ = 74000000,
  parameter int FRAME_HZ    = 50,
  parameter int DEPTH       = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [12:0]            cmd_data,
  input  logic                   enable,
  input  logic                   flush,
  ym_frame_sequencer_if.master   wb,
  output logic                   frame_tick_o,
  output logic                   underrun_o,
  output logic                   overrun_o,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);
  localparam int DIV = CLK_FREQ_HZ / FRAME_HZ;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, DRAIN, ISSUE, GAP
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] div_cnt;
  logic          div_wrap;

  assign div_wrap = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      frame_tick_o <= 1'b0;
    end else begin
      frame_tick_o <= div_wrap;
      div_cnt      <= div_wrap ? '0 : div_cnt + 1'b1;
    end
  end

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, clr;
  logic [12:0]   head;
  logic          skip;

  assign full      = (fifo_level == (AW + 1)'(DEPTH));
  assign empty     = (fifo_level == '0);
  assign cmd_ready = ~full;
  assign clr       = flush & (state == IDLE);
  assign push      = cmd_valid & ~full & ~clr;
  assign pop       = (state == DRAIN) & enable & ~empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef YM_SEQ_SKIP_REDUNDANT_EN
  logic [7:0] shadow [16];

  // 0xD retriggers the envelope, so it is always written.
  assign skip = (head[11:8] != 4'hD) &&
                (shadow[head[11:8]] == head[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        shadow[i] <= (i == 7) ? 8'h3F : 8'h00;
    end else if (pop && !skip) begin
      shadow[head[11:8]] <= head[7:0];
    end
  end
`else
  assign skip = 1'b0;
`endif

  logic [3:0] adr_q;
  logic [7:0] dat_q;
  logic       eof_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q <= '0;
      dat_q <= '0;
      eof_q <= 1'b0;
    end else if (pop) begin
      eof_q <= head[12];
      if (!skip) begin
        adr_q <= head[11:8];
        dat_q <= head[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (enable) state_d = WAIT_TICK;
      WAIT_TICK:
        if (!enable)
          state_d = IDLE;
        else if (frame_tick_o && !empty)
          state_d = DRAIN;
      DRAIN:
        if (!enable)
          state_d = IDLE;
        else if (!empty)
          state_d = skip ? GAP : ISSUE;
      ISSUE:
        if (wb.wb_ack_i) state_d = GAP;
      GAP:
        if (!enable)
          state_d = IDLE;
        else
          state_d = eof_q ? WAIT_TICK : DRAIN;
      default:
        state_d = IDLE;
    endcase
  end

  assign busy = (state == DRAIN) || (state == ISSUE) || (state == GAP);

  assign underrun_o = frame_tick_o & (state == WAIT_TICK) & empty;
  assign overrun_o  = frame_tick_o & busy;

  assign wb.wb_adr_o = {4'h0, adr_q};
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_cyc_o = (state == ISSUE);
  assign wb.wb_stb_o = (state == ISSUE);
  assign wb.wb_we_o  = (state == ISSUE);
endmodule

// File: doc/ym_frame_sequencer.md
Name: ym_frame_sequencer

Overview:
- Wishbone master that plays timed register-write frames into the wb_ym2149 slave, e.g. a YM/VGM-style player fed from the SPI bridge.
- Host pushes (addr, data, end-of-frame) entries into an internal FIFO.
- On each frame tick (default 50 Hz), the block drains one frame's entries as single Wishbone write cycles.

Parameters:
- CLK_FREQ_HZ, 74000000, input clock frequency.
- FRAME_HZ, 50, frame tick rate. Divider is CLK_FREQ_HZ/FRAME_HZ cycles.
- DEPTH, 64, FIFO entries. Power of 2, minimum 4.

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- cmd_valid in 1 host entry valid
- cmd_ready out 1 FIFO not full
- cmd_data in 13 {eof[12], addr[11:8], data[7:0]}
- enable in 1 playback enable
- flush in 1 clear FIFO; honoured only in IDLE
- wb_adr_o out 8 {4'h0, addr}
- wb_dat_o out 8 write data
- wb_cyc_o out 1 bus cycle
- wb_stb_o out 1 strobe
- wb_we_o out 1 write enable, high whenever stb is high
- wb_ack_i in 1 slave acknowledge
- frame_tick_o out 1 one-cycle pulse per frame period
- underrun_o out 1 one-cycle pulse: tick arrived with FIFO empty
- overrun_o out 1 one-cycle pulse: tick arrived while a frame was still draining
- fifo_level out $clog2(DEPTH)+1 current occupancy
- busy out 1 state is DRAIN, ISSUE or GAP

Behaviour:
- Reset values:
  - All outputs 0. cmd_ready is 1 after reset.
  - FIFO empty; state IDLE; tick divider 0.
- FIFO push:
  - A push occurs when cmd_valid & cmd_ready.
  - Full: cmd_ready=0 and the entry is not accepted.
  - Simultaneous push and pop: allowed when not full; level unchanged.
  - Pointers wrap modulo DEPTH.
- Tick divider:
  - Free-running; counts 0..CLK_FREQ_HZ/FRAME_HZ-1.
  - frame_tick_o pulses when the count wraps to 0, independent of enable.
- States:
  - IDLE: enable=0.
  - WAIT_TICK.
  - DRAIN: selects the next entry.
  - ISSUE: bus cycle active.
  - GAP: one idle bus cycle.
- Transitions:
  - IDLE→WAIT_TICK when enable=1.
  - WAIT_TICK, tick with FIFO non-empty → DRAIN.
  - WAIT_TICK, tick with FIFO empty → underrun_o pulse; stay in WAIT_TICK.
  - DRAIN, FIFO non-empty → pop head into the output registers and go to ISSUE. cyc/stb/we assert the cycle after the pop.
  - DRAIN, FIFO empty (frame not terminated) → stall in DRAIN; no bus activity.
  - ISSUE: cyc/stb/we held until wb_ack_i=1. The cycle after ack they deassert and the state is GAP.
  - GAP: one cycle with cyc=stb=0. The slave's !ack gating needs this gap.
  - Leaving GAP: if the issued entry had eof=1 → WAIT_TICK, else → DRAIN.
- Latency:
  - Tick at cycle T → stb high at T+2: pop at T+1.
  - Each write occupies a minimum of 3 cycles on the bus (ISSUE with ack next cycle, plus GAP).
- Overrun:
  - Triggered by a tick while in DRAIN/ISSUE/GAP.
  - overrun_o pulses; the tick is discarded; draining continues.
  - No frame is ever split or dropped.
- enable deasserted mid-frame:
  - An in-flight ISSUE completes through GAP.
  - Then go to IDLE. Remaining FIFO entries are retained.
  - Re-enabling resumes at WAIT_TICK.
- flush in IDLE:
  - Empties the FIFO in one cycle.
  - A push in the same cycle is dropped.
  - flush in any other state is ignored.
- Address: upper 4 bits of wb_adr_o are always 0.
- wb_dat_o/wb_adr_o hold their last values when stb=0.
- Reset mid-cycle: cyc/stb drop immediately (asynchronous); FIFO is cleared.

Optional Feature:
- Macro: YM_SEQ_SKIP_REDUNDANT_EN.
- When defined:
  - The block keeps a 16x8 shadow of the last value written per address; reset value 0, except address 7 which resets to 8'h3F to match the slave's reset.
  - An entry whose data equals the shadow is popped without a bus cycle: DRAIN→GAP-equivalent, 1 cycle, and the eof rule still applies.
  - Address 0xD is never skipped, because a write retriggers the envelope.
  - flush does not clear the shadow.
- When undefined: every entry produces a bus write; no shadow storage.

Test Plan:
- Reset, then push {eof=0,0x0,0x55}, {eof=1,0x8,0x0F}, enable=1 → after the first tick: write adr 0x00 dat 0x55, then adr 0x08 dat 0x0F. stb rises 2 cycles after the tick; one GAP cycle between writes; WAIT_TICK afterwards.
- enable=1 with FIFO empty → underrun_o pulses exactly once per tick; no wb_cyc_o activity.
- Push 64 entries (DEPTH=64) → cmd_ready=0 and fifo_level=64; the 65th push is ignored; after one pop, cmd_ready=1.
- Frame of 3 entries with no eof, FIFO then empty → stall in DRAIN. A tick during the stall gives an overrun_o pulse. Pushing {eof=1,0xD,0x0E} completes the frame, and the adr 0x0D write occurs.
- Drop enable during the ISSUE of entry 2 of 4 → that write completes with ack, then IDLE with fifo_level=2. flush → level 0.
- With YM_SEQ_SKIP_REDUNDANT_EN: write 0x7=0x3F, then 0x0=0x00, then 0xD=0x00 → only the 0xD write appears on the bus. Without the macro, all three appear.
